// File: rtl/spu_branch_pkg.sv
// SPU branch unit shared types: formats, opcodes, branch kinds
// and the slot carried between pipeline stages.
package spu_branch_pkg;

  localparam int PC_MAX = 32;
  typedef logic [PC_MAX-1:0] pc_t;

  localparam logic [2:0] FMT_RR   = 3'd0;
  localparam logic [2:0] FMT_RI16 = 3'd5;
  localparam logic [2:0] FMT_RI18 = 3'd6;

  localparam logic [10:0] OP_BR    = 11'b00001100100;
  localparam logic [10:0] OP_BRA   = 11'b00001100000;
  localparam logic [10:0] OP_BRSL  = 11'b00001100110;
  localparam logic [10:0] OP_BRASL = 11'b00001100010;
  localparam logic [10:0] OP_BRZ   = 11'b00001000000;
  localparam logic [10:0] OP_BRNZ  = 11'b00001000010;
  localparam logic [10:0] OP_BRHZ  = 11'b00001000100;
  localparam logic [10:0] OP_BRHNZ = 11'b00001000110;
  localparam logic [10:0] OP_BI    = 11'b00110101000;
  localparam logic [10:0] OP_HBRR  = 11'b00000001001;
  localparam logic [10:0] OP_HBRA  = 11'b00000001000;

  typedef enum logic [2:0] {
    REL, ABS, IND, CONDW, CONDH, HINT_R, HINT_A
  } kind_e;

  // For hint kinds, pc holds the hint key and target the hinted target.
  typedef struct packed {
    logic       valid;
    kind_e      kind;
    logic       link;
    pc_t        pc;
    pc_t        target;
    logic       cond_ok;
    logic [6:0] rt_addr;
    logic       reg_write;
  } slot_t;

  function automatic logic is_hint(kind_e k);
    return (k == HINT_R) || (k == HINT_A);
  endfunction

endpackage

// File: rtl/branch_hint_table.sv
// Branch-hint table: keyed overwrite or round-robin fill,
// lowest-index lookup, entry consumed on hit.
module branch_hint_table
  import spu_branch_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int HINT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [PC_WIDTH-1:0] wr_key,
  input  logic [PC_WIDTH-1:0] wr_target,
  input  logic                lk_en,
  input  logic [PC_WIDTH-1:0] lk_key,
  output logic                lk_hit,
  output logic [PC_WIDTH-1:0] lk_target
);

  localparam int IW = $clog2(HINT_DEPTH);

  logic [HINT_DEPTH-1:0] vld;
  logic [PC_WIDTH-1:0]   key [HINT_DEPTH];
  logic [PC_WIDTH-1:0]   tgt [HINT_DEPTH];
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         lk_idx;
  logic [IW-1:0]         wr_idx;
  logic                  lk_m;
  logic                  wr_m;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    lk_m   = 1'b0;
    wr_m   = 1'b0;
    lk_idx = '0;
    wr_idx = ptr;
    for (int i = HINT_DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && key[i] == lk_key) begin
        lk_m   = 1'b1;
        lk_idx = IW'(i);
      end
      if (vld[i] && key[i] == wr_key) begin
        wr_m   = 1'b1;
        wr_idx = IW'(i);
      end
    end
  end

  assign lk_hit    = lk_en && lk_m;
  assign lk_target = tgt[lk_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      ptr <= '0;
      for (int i = 0; i < HINT_DEPTH; i++) begin
        key[i] <= '0;
        tgt[i] <= '0;
      end
    end else begin
      if (lk_hit)
        vld[lk_idx] <= 1'b0;
      if (wr_en) begin
        vld[wr_idx] <= 1'b1;
        key[wr_idx] <= wr_key;
        tgt[wr_idx] <= wr_target;
        if (!wr_m)
          ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_unit_hinted.sv
// SPU odd-pipe branch unit with hint table, configurable
// latency and squash of younger ops on mispredict.
module branch_unit_hinted
  import spu_branch_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int LATENCY    = 1,
  parameter int HINT_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [10:0]         op,
  input  logic [2:0]          format,
  input  logic [6:0]          rt_addr,
  input  logic [127:0]        ra,
  input  logic [17:0]         imm,
  input  logic                reg_write,
  input  logic [PC_WIDTH-1:0] pc_in,
  output logic [127:0]        rt_wb,
  output logic [6:0]          rt_addr_wb,
  output logic                reg_write_wb,
  output logic [PC_WIDTH-1:0] pc_wb,
  output logic                branch_taken,
  output logic                hint_hit,
  output logic                flush,
  output logic [15:0]         mispredict_count
);

  logic [31:0] ra_w;
  logic [31:0] sx16;
  logic [31:0] zx16;
  logic [31:0] ix32;
  logic [31:0] hkey;
  logic [31:0] hrel;
  logic [31:0] habs;
  logic        i16;
  logic        i18;
  logic        irr;
  logic        known;
  logic        link;
  logic        neg;
  kind_e       kind;
  slot_t       dec;
  slot_t       res;

  // SPU bit 0 is the MSB: ra[0:31] is ra[127:96], imm[2:17] is imm[15:0].
  assign ra_w = ra[127:96];
  assign sx16 = {{16{imm[15]}}, imm[15:0]};
  assign zx16 = {16'd0, imm[15:0]};
  assign ix32 = {2'd0, ra_w[31:2]};
  assign hkey = {23'd0, imm[8:0]};
  assign hrel = {{23{imm[17]}}, imm[17:9]};
  assign habs = {23'd0, imm[17:9]};

  assign i16 = format == FMT_RI16;
  assign i18 = format == FMT_RI18;
  assign irr = format == FMT_RR;

  always_comb begin
    kind  = REL;
    known = 1'b1;
    link  = 1'b0;
    neg   = 1'b0;
    unique case (1'b1)
      i16 && op == OP_BR:    kind = REL;
      i16 && op == OP_BRA:   kind = ABS;
      i16 && op == OP_BRSL: begin
        kind = REL;
        link = 1'b1;
      end
      i16 && op == OP_BRASL: begin
        kind = ABS;
        link = 1'b1;
      end
      i16 && op == OP_BRZ:   kind = CONDW;
      i16 && op == OP_BRNZ: begin
        kind = CONDW;
        neg  = 1'b1;
      end
      i16 && op == OP_BRHZ:  kind = CONDH;
      i16 && op == OP_BRHNZ: begin
        kind = CONDH;
        neg  = 1'b1;
      end
      irr && op == OP_BI:    kind = IND;
      i18 && op == OP_HBRR:  kind = HINT_R;
      i18 && op == OP_HBRA:  kind = HINT_A;
      default:               known = 1'b0;
    endcase
  end

  // Ops presented while a flush is visible are dropped here.
  always_comb begin
    dec           = '0;
    dec.valid     = known && !flush;
    dec.kind      = kind;
    dec.link      = link;
    dec.rt_addr   = rt_addr;
    dec.reg_write = reg_write;
    dec.cond_ok   = 1'b1;
    dec.pc        = pc_t'(pc_in);
    dec.target    = pc_t'(pc_in + sx16[PC_WIDTH-1:0]);
    unique case (kind)
      ABS:   dec.target  = pc_t'(zx16[PC_WIDTH-1:0]);
      IND:   dec.target  = pc_t'(ix32[PC_WIDTH-1:0]);
      CONDW: dec.cond_ok = neg ^ (ra_w == 32'd0);
      CONDH: dec.cond_ok = neg ^ (ra_w[15:0] == 16'd0);
      HINT_R: begin
        dec.pc     = pc_t'(pc_in + hkey[PC_WIDTH-1:0]);
        dec.target = pc_t'(pc_in + hrel[PC_WIDTH-1:0]);
      end
      HINT_A: begin
        dec.pc     = pc_t'(pc_in + hkey[PC_WIDTH-1:0]);
        dec.target = pc_t'(habs[PC_WIDTH-1:0]);
      end
      default: ;
    endcase
  end

  logic                br;
  logic                hw;
  logic                taken;
  logic                hit;
  logic                flush_d;
  logic [PC_WIDTH-1:0] rpc;
  logic [PC_WIDTH-1:0] rtgt;
  logic [PC_WIDTH-1:0] pc1;
  logic [PC_WIDTH-1:0] htgt;

  generate
    if (LATENCY == 1) begin : g_direct
      assign res = dec;
    end else begin : g_pipe
      slot_t pipe [LATENCY-1];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe <= '{default: '0};
        end else if (flush_d) begin
          pipe <= '{default: '0};
        end else begin
          pipe[0] <= dec;
          for (int i = 1; i < LATENCY - 1; i++)
            pipe[i] <= pipe[i-1];
        end
      end
      assign res = pipe[LATENCY-2];
    end
  endgenerate

  assign br    = res.valid && !is_hint(res.kind);
  assign hw    = res.valid && is_hint(res.kind);
  assign rpc   = res.pc[PC_WIDTH-1:0];
  assign rtgt  = res.target[PC_WIDTH-1:0];
  assign pc1   = rpc + 1'b1;
  assign taken = br && res.cond_ok;

  branch_hint_table #(
    .PC_WIDTH  (PC_WIDTH),
    .HINT_DEPTH(HINT_DEPTH)
  ) u_tbl (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (hw),
    .wr_key   (rpc),
    .wr_target(rtgt),
    .lk_en    (br),
    .lk_key   (rpc),
    .lk_hit   (hit),
    .lk_target(htgt)
  );

  assign flush_d = br && ((taken != hit) ||
                   (taken && hit && rtgt != htgt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rt_wb            <= '0;
      rt_addr_wb       <= '0;
      reg_write_wb     <= 1'b0;
      pc_wb            <= '0;
      branch_taken     <= 1'b0;
      hint_hit         <= 1'b0;
      flush            <= 1'b0;
      mispredict_count <= '0;
    end else begin
      branch_taken <= taken;
      hint_hit     <= hit;
      flush        <= flush_d;
      pc_wb        <= !br ? '0 : (taken ? rtgt : pc1);
      rt_wb        <= (br && res.link) ?
                      {32'(pc1), 96'd0} : '0;
      rt_addr_wb   <= (br && res.link) ? res.rt_addr : '0;
      reg_write_wb <= br && res.link && res.reg_write;
      if (flush_d && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ra[95:0], res.pc, res.target};

endmodule

// File: tb/tb_branch_unit_hinted.sv
// Scoreboard bench for branch_unit_hinted at LATENCY 1 and 3,
// sharing one stimulus stream against a behavioural model.
module tb_branch_unit_hinted;

  typedef struct packed {
    logic [127:0] rt_wb;
    logic [6:0]   rt_addr_wb;
    logic         reg_write_wb;
    logic [7:0]   pc_wb;
    logic         taken;
    logic         hit;
    logic         flush;
    logic [15:0]  cnt;
  } out_t;

  typedef struct {
    int   due;
    out_t o;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [10:0]  op;
  logic [2:0]   fmt;
  logic [6:0]   rt;
  logic [127:0] ra;
  logic [17:0]  imm;
  logic         rw;
  logic [7:0]   pc;

  logic [127:0] rt_wb1, rt_wb3;
  logic [6:0]   rta1, rta3;
  logic         rww1, rww3;
  logic [7:0]   pcw1, pcw3;
  logic         tk1, tk3, hh1, hh3, fl1, fl3;
  logic [15:0]  mc1, mc3;
  out_t         got1, got3;

  assign got1 = {rt_wb1, rta1, rww1, pcw1, tk1, hh1, fl1, mc1};
  assign got3 = {rt_wb3, rta3, rww3, pcw3, tk3, hh3, fl3, mc3};

  branch_unit_hinted #(.PC_WIDTH(8), .LATENCY(1), .HINT_DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .op(op), .format(fmt),
    .rt_addr(rt), .ra(ra), .imm(imm), .reg_write(rw), .pc_in(pc),
    .rt_wb(rt_wb1), .rt_addr_wb(rta1), .reg_write_wb(rww1),
    .pc_wb(pcw1), .branch_taken(tk1), .hint_hit(hh1),
    .flush(fl1), .mispredict_count(mc1)
  );

  branch_unit_hinted #(.PC_WIDTH(8), .LATENCY(3), .HINT_DEPTH(4)) u3 (
    .clk(clk), .reset(reset), .op(op), .format(fmt),
    .rt_addr(rt), .ra(ra), .imm(imm), .reg_write(rw), .pc_in(pc),
    .rt_wb(rt_wb3), .rt_addr_wb(rta3), .reg_write_wb(rww3),
    .pc_wb(pcw3), .branch_taken(tk3), .hint_hit(hh3),
    .flush(fl3), .mispredict_count(mc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t q1[$];
  exp_t q3[$];

  // Model state per instance (0: LATENCY 1, 1: LATENCY 3)
  bit hv[2][4];
  int hk[2][4];
  int ht[2][4];
  int hp[2]   = '{0, 0};
  int cnt[2]  = '{0, 0};
  int kill[2] = '{-1, -1};

  localparam logic [10:0] BR    = 11'b00001100100;
  localparam logic [10:0] BRA   = 11'b00001100000;
  localparam logic [10:0] BRSL  = 11'b00001100110;
  localparam logic [10:0] BRASL = 11'b00001100010;
  localparam logic [10:0] BRZ   = 11'b00001000000;
  localparam logic [10:0] BRNZ  = 11'b00001000010;
  localparam logic [10:0] BRHZ  = 11'b00001000100;
  localparam logic [10:0] BRHNZ = 11'b00001000110;
  localparam logic [10:0] BI    = 11'b00110101000;
  localparam logic [10:0] HBRR  = 11'b00000001001;
  localparam logic [10:0] HBRA  = 11'b00000001000;

  logic [10:0] ops [11] = '{BR, BRA, BRSL, BRASL, BRZ, BRNZ,
                            BRHZ, BRHNZ, BI, HBRR, HBRA};
  logic [2:0]  fms [11] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5,
                            3'd5, 3'd5, 3'd0, 3'd6, 3'd6};

  function automatic void check(string nm, out_t g, out_t e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", nm, edges, g, e);
    end
  endfunction

  // Kinds: 0 rel 1 abs 2 ind 3 brz 4 brnz 5 brhz 6 brhnz 7 hbrr 8 hbra
  function automatic out_t model(int i, int lat, int k,
      logic [10:0] o_, logic [2:0] f_, logic [6:0] r_,
      logic [127:0] a_, logic [17:0] m_, logic w_, logic [7:0] p_);
    out_t o;
    int kind, s16, hi9, pcv, tgt, key, idx, htg;
    bit lnk, tk, hit, fl;
    logic [31:0] w;
    o = '0;
    kind = -1;
    lnk = 0;
    if (f_ == 3'd5) begin
      case (o_)
        BR:    kind = 0;
        BRA:   kind = 1;
        BRSL:  begin kind = 0; lnk = 1; end
        BRASL: begin kind = 1; lnk = 1; end
        BRZ:   kind = 3;
        BRNZ:  kind = 4;
        BRHZ:  kind = 5;
        BRHNZ: kind = 6;
        default: kind = -1;
      endcase
    end else if (f_ == 3'd0 && o_ == BI) kind = 2;
    else if (f_ == 3'd6 && o_ == HBRR) kind = 7;
    else if (f_ == 3'd6 && o_ == HBRA) kind = 8;
    o.cnt = 16'(cnt[i]);
    if (kind < 0 || k <= kill[i]) return o;
    pcv = int'(p_);
    s16 = int'(m_) % 65536;
    if (s16 >= 32768) s16 -= 65536;
    hi9 = int'(m_) / 512;
    w = a_[127:96];
    if (kind >= 7) begin
      key = (pcv + int'(m_) % 512) & 255;
      if (kind == 7) tgt = (pcv + (hi9 >= 256 ? hi9 - 512 : hi9)) & 255;
      else tgt = hi9 & 255;
      idx = -1;
      for (int j = 0; j < 4; j++)
        if (idx < 0 && hv[i][j] && hk[i][j] == key) idx = j;
      if (idx < 0) begin
        idx = hp[i];
        hp[i] = (hp[i] + 1) % 4;
      end
      hv[i][idx] = 1;
      hk[i][idx] = key;
      ht[i][idx] = tgt;
      return o;
    end
    tk = 1;
    tgt = (pcv + s16) & 255;
    case (kind)
      1: tgt = (int'(m_) % 65536) % 256;
      2: tgt = int'(w / 4) % 256;
      3: tk = (w == 0);
      4: tk = (w != 0);
      5: tk = (w % 65536 == 0);
      6: tk = (w % 65536 != 0);
      default: ;
    endcase
    idx = -1;
    for (int j = 0; j < 4; j++)
      if (idx < 0 && hv[i][j] && hk[i][j] == pcv) idx = j;
    hit = idx >= 0;
    htg = hit ? ht[i][idx] : 0;
    if (hit) hv[i][idx] = 0;
    fl = (tk != hit) || (tk && hit && tgt != htg);
    o.taken = tk;
    o.hit   = hit;
    o.flush = fl;
    o.pc_wb = 8'(tk ? tgt : (pcv + 1) & 255);
    if (lnk) begin
      o.rt_wb        = {32'((pcv + 1) & 255), 96'd0};
      o.rt_addr_wb   = r_;
      o.reg_write_wb = w_;
    end
    if (fl) begin
      if (cnt[i] < 65535) cnt[i]++;
      kill[i] = k + lat;
    end
    o.cnt = 16'(cnt[i]);
    return o;
  endfunction

  task automatic send(logic [10:0] o_, logic [2:0] f_, logic [6:0] r_,
      logic [127:0] a_, logic [17:0] m_, logic w_, logic [7:0] p_);
    exp_t e;
    op = o_; fmt = f_; rt = r_; ra = a_; imm = m_; rw = w_; pc = p_;
    e.due = edges + 1;
    e.o = model(0, 1, edges, o_, f_, r_, a_, m_, w_, p_);
    q1.push_back(e);
    e.due = edges + 3;
    e.o = model(1, 3, edges, o_, f_, r_, a_, m_, w_, p_);
    q3.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic nops(int n);
    for (int j = 0; j < n; j++) send('0, '0, '0, '0, '0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_en && q1.size() > 0 && q1[0].due == edges)
      check("lat1", got1, q1.pop_front().o);
    if (mon_en && q3.size() > 0 && q3[0].due == edges)
      check("lat3", got3, q3.pop_front().o);
  end

  logic [127:0] one_w = {32'd1, 96'd0};

  initial begin
    int sel;
    int z;
    logic [127:0] a;
    reset = 1'b0;
    op = BR; fmt = 3'd5; rt = 7'd9; ra = '1;
    imm = 18'($urandom); rw = 1'b1; pc = 8'($urandom);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      check("reset_lat1", got1, '0);
      check("reset_lat3", got3, '0);
    end
    mon_en = 1'b1;
    reset = 1'b1;
    nops(4);

    send(BR, 3'd5, 7'd0, '0, 18'd5, 1'b0, 8'd10);
    nops(4);
    send(HBRR, 3'd6, 7'd0, '0, 18'd4100, 1'b0, 8'd20);
    send(BR, 3'd5, 7'd0, '0, 18'd4, 1'b0, 8'd24);
    nops(4);
    send(BR, 3'd5, 7'd0, '0, 18'd4, 1'b0, 8'd24);
    nops(4);
    send(BRZ, 3'd5, 7'd0, one_w, 18'd7, 1'b0, 8'd30);
    send(BRNZ, 3'd5, 7'd0, one_w, 18'h3FFFE, 1'b0, 8'd40);
    nops(4);
    send(BRSL, 3'd5, 7'd3, '0, 18'd6, 1'b1, 8'd50);
    nops(4);

    send(BR, 3'd5, 7'd0, '0, 18'd1, 1'b0, 8'd60);
    send(BRSL, 3'd5, 7'd5, '0, 18'd3, 1'b1, 8'd61);
    send(HBRR, 3'd6, 7'd0, '0, {9'd1, 9'd2}, 1'b0, 8'd62);
    nops(4);
    send(BR, 3'd5, 7'd0, '0, 18'd3, 1'b0, 8'd64);
    nops(4);
    for (int j = 0; j < 5; j++)
      send(HBRA, 3'd6, 7'd0, '0, {9'(200 + j), 9'd0}, 1'b0, 8'(100 + j));
    nops(4);
    for (int j = 0; j < 5; j++) begin
      send(BRA, 3'd5, 7'd0, '0, 18'(200 + j), 1'b0, 8'(100 + j));
      nops(4);
    end

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 13);
      z = $urandom_range(0, 2);
      a = {$urandom, $urandom, $urandom, $urandom};
      if (z == 0) a[127:96] = '0;
      if (z == 1) a[111:96] = '0;
      if (sel <= 10 && fms[sel] == 3'd6)
        send(ops[sel], fms[sel], 7'($urandom), a,
             {9'($urandom), 9'($urandom_range(0, 7))},
             1'($urandom), 8'($urandom_range(0, 15)));
      else if (sel <= 10)
        send(ops[sel], fms[sel], 7'($urandom), a, 18'($urandom),
             1'($urandom), 8'($urandom_range(0, 15)));
      else if (sel == 11)
        nops(1);
      else if (sel == 12)
        send(11'($urandom), 3'($urandom), 7'($urandom), a,
             18'($urandom), 1'($urandom), 8'($urandom));
      else
        send(BR, 3'd6, 7'($urandom), a, 18'($urandom), 1'b1,
             8'($urandom_range(0, 15)));
    end
    nops(4);
    for (int j = 0; j < 10 && (q1.size() + q3.size()) > 0; j++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (q1.size() + q3.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q1.size() + q3.size());
    end

    send(BR, 3'd5, 7'd1, '0, 18'd9, 1'b1, 8'd3);
    send(BRSL, 3'd5, 7'd2, '0, 18'd9, 1'b1, 8'd4);
    mon_en = 1'b0;
    q1.delete();
    q3.delete();
    #2 reset = 1'b0;
    #1;
    check("midreset_lat1", got1, '0);
    check("midreset_lat3", got3, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
